// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control sequencer.
// Shares one ALU and one unified memory port across FETCH, DECODE, EXECUTE,
// MEM and WRITEBACK cycles, waits on mem_ready and counts retired instructions.
// Optional build macro: ILLEGAL_TRAP_EN. When defined, illegal instructions
// park the FSM in TRAP and set the sticky illegal flag. When undefined, they
// retire as NOPs without counting.
module multicycle_ctrl_fsm #(
  parameter int INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             op,
  input  logic [2:0]             funct3,
  input  logic                   funct7,
  input  logic                   BrEn,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   IRWrite,
  output logic                   AdrSrc,
  output logic                   MemWrite,
  output logic                   RegWrite,
  output logic [1:0]             ResultSrc,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [2:0]             ImmSrc,
  output logic [3:0]             ALUControl,
  output logic [3:0]             SLControl,
  output logic [2:0]             BrCtrl,
  output logic [INSTR_CNT_W-1:0] instret,
  output logic                   illegal,
  output logic [3:0]             state_dbg
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_BRANCH   = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_JALR2    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  state_t                   r_state;
  logic [INSTR_CNT_W-1:0]   r_instret;
  logic [INSTR_CNT_W-1:0]   w_instretInc;
  logic                     w_brF3Legal;
  logic                     w_pcWrite;
  logic                     w_irWrite;
  logic                     w_memWrite;
  logic                     w_regWrite;

`ifdef ILLEGAL_TRAP_EN
  logic                     r_illegal;
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  // Branch funct3 values 010 and 011 are not defined in RV32I
  assign w_brF3Legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
  assign w_instretInc = r_instret + INSTR_CNT_W'(1);

  // Shared ALU operation decode; alt selects sub (funct3 000) or sra (funct3 101)
  function automatic logic [3:0] aluDecode(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = 4'b1101;
      3'b010:  code = 4'b0101;
      3'b011:  code = 4'b0100;
      3'b100:  code = 4'b0111;
      3'b101:  code = alt ? 4'b1011 : 4'b1001;
      3'b110:  code = 4'b0011;
      default: code = 4'b0010;
    endcase
    return code;
  endfunction

  // State register, retired-instruction counter and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
`ifdef ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXEC_R;
            OP_ITYPE:          r_state <= S_EXEC_I;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_LUI:            r_state <= S_LUI;
            OP_AUIPC:          r_state <= S_AUIPC;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              r_state   <= S_TRAP;
              r_illegal <= 1'b1;
`else
              r_state   <= S_FETCH;
`endif
            end
          endcase
        end
        S_MEMADR: begin
          r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          if (mem_ready) r_state <= S_MEMWB;
        end
        S_MEMWB: begin
          r_state   <= S_FETCH;
          r_instret <= w_instretInc;
        end
        S_MEMWRITE: begin
          if (mem_ready) begin
            r_state   <= S_FETCH;
            r_instret <= w_instretInc;
          end
        end
        S_EXEC_R, S_EXEC_I, S_JAL, S_JALR2, S_AUIPC: begin
          r_state <= S_ALUWB;
        end
        S_ALUWB, S_LUI: begin
          r_state   <= S_FETCH;
          r_instret <= w_instretInc;
        end
        S_JALR: begin
          r_state <= S_JALR2;
        end
        S_BRANCH: begin
          if (w_brF3Legal) begin
            r_state   <= S_FETCH;
            r_instret <= w_instretInc;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
`else
            r_state   <= S_FETCH;
`endif
          end
        end
        S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
          r_state <= S_TRAP;
`else
          r_state <= S_FETCH;
`endif
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  // Per-state datapath controls; anything not set for a state stays at its default
  always_comb begin
    w_pcWrite  = 1'b0;
    w_irWrite  = 1'b0;
    w_memWrite = 1'b0;
    w_regWrite = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    SLControl  = 4'b1111;
    BrCtrl     = 3'b000;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irWrite = mem_ready;
        w_pcWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR, S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        SLControl = {1'b0, funct3};
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regWrite = 1'b1;
        SLControl  = {1'b0, funct3};
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memWrite = 1'b1;
        SLControl  = {1'b1, funct3};
      end
      S_EXEC_R: begin
        ALUSrcA    = 2'b10;
        ALUControl = aluDecode(funct3, funct7);
      end
      S_EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = aluDecode(funct3, (funct3 == 3'b101) && funct7);
      end
      S_ALUWB: begin
        w_regWrite = 1'b1;
      end
      S_JAL, S_JALR2: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        w_pcWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        BrCtrl     = funct3;
        w_pcWrite  = BrEn && w_brF3Legal;
      end
      S_LUI: begin
        ResultSrc  = 2'b11;
        w_regWrite = 1'b1;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_TRAP: begin
        w_pcWrite = 1'b0;
      end
      default: begin
        w_pcWrite = 1'b0;
      end
    endcase
  end

  // Architectural strobes are held low for as long as reset is asserted
  assign PCWrite   = w_pcWrite  & rst_n;
  assign IRWrite   = w_irWrite  & rst_n;
  assign MemWrite  = w_memWrite & rst_n;
  assign RegWrite  = w_regWrite & rst_n;
  assign instret   = r_instret;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for multicycle_ctrl_fsm.
// Each cycle the full control word is compared with a hand-computed vector.
// Field order of the observed word:
// {state, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA,
//  ALUSrcB, ImmSrc, ALUControl, SLControl, BrCtrl}
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        BrEn;
  logic        mem_ready;
  logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc, BrCtrl;
  logic [3:0]  ALUControl, SLControl, state_dbg;
  logic [31:0] instret;
  logic        illegal;

  logic        nPCWrite, nIRWrite, nAdrSrc, nMemWrite, nRegWrite;
  logic [1:0]  nResultSrc, nALUSrcA, nALUSrcB;
  logic [2:0]  nImmSrc, nBrCtrl;
  logic [3:0]  nALUControl, nSLControl, nState;
  logic [1:0]  nInstret;
  logic        nIllegal;

  logic [28:0] obs;
  logic [29:0] nObs;
  int          assertCount = 0;
  int          failCount = 0;
  logic [31:0] expInstret = 32'd0;

  assign obs  = {state_dbg, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ImmSrc, ALUControl, SLControl, BrCtrl};
  assign nObs = {nIllegal, nState, nPCWrite, nIRWrite, nAdrSrc, nMemWrite, nRegWrite,
                 nResultSrc, nALUSrcA, nALUSrcB, nImmSrc, nALUControl, nSLControl, nBrCtrl};

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.INSTR_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .BrEn(BrEn), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .SLControl(SLControl), .BrCtrl(BrCtrl),
    .instret(instret), .illegal(illegal), .state_dbg(state_dbg)
  );

  // Narrow counter instance, used to observe wrap-around
  multicycle_ctrl_fsm #(.INSTR_CNT_W(2)) dutNarrow (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .BrEn(BrEn), .mem_ready(mem_ready),
    .PCWrite(nPCWrite), .IRWrite(nIRWrite), .AdrSrc(nAdrSrc), .MemWrite(nMemWrite),
    .RegWrite(nRegWrite), .ResultSrc(nResultSrc), .ALUSrcA(nALUSrcA), .ALUSrcB(nALUSrcB),
    .ImmSrc(nImmSrc), .ALUControl(nALUControl), .SLControl(nSLControl), .BrCtrl(nBrCtrl),
    .instret(nInstret), .illegal(nIllegal), .state_dbg(nState)
  );

  // Reset holds FETCH with all strobes low even while mem_ready is high
  task automatic test_reset();
    logic [28:0] expVal;
    rst_n = 1'b0; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b0; BrEn = 1'b0;
    #3;
    expVal = {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 4'b1111, 3'b000};
    assertCount++;
    if (obs !== expVal) begin failCount++; $display("[TB] FAIL reset_obs got %b want %b", obs, expVal); end
    assertCount++;
    if ({instret, illegal} !== 33'd0) begin failCount++; $display("[TB] FAIL reset_cnt instret=%0d illegal=%b want 0 0", instret, illegal); end
    @(negedge clk); #1;
    assertCount++;
    if (obs !== expVal) begin failCount++; $display("[TB] FAIL reset_held got %b want %b", obs, expVal); end
    mem_ready = 1'b0; rst_n = 1'b1; #1;
    expVal = {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 4'b1111, 3'b000};
    assertCount++;
    if (obs !== expVal) begin failCount++; $display("[TB] FAIL reset_release got %b want %b", obs, expVal); end
  endtask

  // add x3,x1,x2 : FETCH, DECODE, EXEC_R, ALUWB, FETCH
  task automatic test_add();
    logic [28:0] expSeq [5];
    bit          rdy [5];
    op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b0;
    rdy = '{1, 0, 0, 0, 0};
    expSeq = '{
      {4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 4'b1111, 3'b000}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = rdy[i]; #1;
      assertCount++;
      if (obs !== expSeq[i]) begin failCount++; $display("[TB] FAIL add_cycle%0d got %b want %b", i, obs, expSeq[i]); end
    end
    expInstret++;
    assertCount++;
    if (instret !== expInstret) begin failCount++; $display("[TB] FAIL add_instret got %0d want %0d", instret, expInstret); end
  endtask

  // lw with mem_ready low for three MEMREAD cycles
  task automatic test_load();
    logic [28:0] expSeq [9];
    bit          rdy [9];
    op = 7'b0000011; funct3 = 3'b010; funct7 = 1'b0;
    rdy = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    expSeq = '{
      {4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd3, 5'b00100, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 4'b0010, 3'b000},
      {4'd3, 5'b00100, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 4'b0010, 3'b000},
      {4'd3, 5'b00100, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 4'b0010, 3'b000},
      {4'd3, 5'b00100, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 4'b0010, 3'b000},
      {4'd4, 5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000, 4'b0010, 3'b000},
      {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 4'b1111, 3'b000}};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); mem_ready = rdy[i]; #1;
      assertCount++;
      if (obs !== expSeq[i]) begin failCount++; $display("[TB] FAIL lw_cycle%0d got %b want %b", i, obs, expSeq[i]); end
    end
    expInstret++;
    assertCount++;
    if (instret !== expInstret) begin failCount++; $display("[TB] FAIL lw_instret got %0d want %0d", instret, expInstret); end
  endtask

  // sb with mem_ready delayed two cycles: MemWrite high for three cycles
  task automatic test_store();
    logic [28:0] expSeq [7];
    bit          rdy [7];
    op = 7'b0100011; funct3 = 3'b000; funct7 = 1'b0;
    rdy = '{1, 0, 0, 0, 0, 1, 0};
    expSeq = '{
      {4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 3'b001, 4'b0000, 4'b1111, 3'b000},
      {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b001, 4'b0000, 4'b1111, 3'b000},
      {4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 4'b1111, 3'b000},
      {4'd5, 5'b00110, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 4'b1000, 3'b000},
      {4'd5, 5'b00110, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 4'b1000, 3'b000},
      {4'd5, 5'b00110, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 4'b1000, 3'b000},
      {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b001, 4'b0000, 4'b1111, 3'b000}};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); mem_ready = rdy[i]; #1;
      assertCount++;
      if (obs !== expSeq[i]) begin failCount++; $display("[TB] FAIL sb_cycle%0d got %b want %b", i, obs, expSeq[i]); end
    end
    expInstret++;
    assertCount++;
    if (instret !== expInstret) begin failCount++; $display("[TB] FAIL sb_instret got %0d want %0d", instret, expInstret); end
  endtask

  // beq taken, then bne not taken; each takes three cycles
  task automatic test_branch();
    logic [28:0] expSeq [4];
    bit          rdy [4];
    op = 7'b1100011; funct7 = 1'b0;
    rdy = '{1, 0, 0, 0};
    for (int k = 0; k < 2; k++) begin
      funct3 = (k == 0) ? 3'b000 : 3'b001;
      BrEn   = (k == 0);
      expSeq = '{
        {4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 3'b010, 4'b0000, 4'b1111, 3'b000},
        {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b010, 4'b0000, 4'b1111, 3'b000},
        {4'd11, (k == 0) ? 5'b10000 : 5'b00000, 2'b00, 2'b10, 2'b00, 3'b010, 4'b0001, 4'b1111,
         (k == 0) ? 3'b000 : 3'b001},
        {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b010, 4'b0000, 4'b1111, 3'b000}};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); mem_ready = rdy[i]; #1;
        assertCount++;
        if (obs !== expSeq[i]) begin failCount++; $display("[TB] FAIL branch%0d_cycle%0d got %b want %b", k, i, obs, expSeq[i]); end
      end
      expInstret++;
      assertCount++;
      if (instret !== expInstret) begin failCount++; $display("[TB] FAIL branch%0d_instret got %0d want %0d", k, instret, expInstret); end
    end
    BrEn = 1'b0;
  endtask

  // jal: DECODE, JAL (PCWrite), ALUWB
  task automatic test_jal();
    logic [28:0] expSeq [5];
    bit          rdy [5];
    op = 7'b1101111; funct3 = 3'b000; funct7 = 1'b0;
    rdy = '{1, 0, 0, 0, 0};
    expSeq = '{
      {4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 3'b011, 4'b0000, 4'b1111, 3'b000},
      {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b011, 4'b0000, 4'b1111, 3'b000},
      {4'd9, 5'b10000, 2'b00, 2'b01, 2'b10, 3'b011, 4'b0000, 4'b1111, 3'b000},
      {4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b011, 4'b0000, 4'b1111, 3'b000},
      {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b011, 4'b0000, 4'b1111, 3'b000}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = rdy[i]; #1;
      assertCount++;
      if (obs !== expSeq[i]) begin failCount++; $display("[TB] FAIL jal_cycle%0d got %b want %b", i, obs, expSeq[i]); end
    end
    expInstret++;
    assertCount++;
    if (instret !== expInstret) begin failCount++; $display("[TB] FAIL jal_instret got %0d want %0d", instret, expInstret); end
  endtask

  // jalr: DECODE, JALR, JALR2 (PCWrite), ALUWB (RegWrite)
  task automatic test_jalr();
    logic [28:0] expSeq [6];
    bit          rdy [6];
    op = 7'b1100111; funct3 = 3'b000; funct7 = 1'b0;
    rdy = '{1, 0, 0, 0, 0, 0};
    expSeq = '{
      {4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd10, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd14, 5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 4'b1111, 3'b000},
      {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 4'b1111, 3'b000}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mem_ready = rdy[i]; #1;
      assertCount++;
      if (obs !== expSeq[i]) begin failCount++; $display("[TB] FAIL jalr_cycle%0d got %b want %b", i, obs, expSeq[i]); end
    end
    expInstret++;
    assertCount++;
    if (instret !== expInstret) begin failCount++; $display("[TB] FAIL jalr_instret got %0d want %0d", instret, expInstret); end
  endtask

  // lui writes ImmExt directly; auipc goes through ALUWB
  task automatic test_upper();
    logic [28:0] expLui [4];
    logic [28:0] expAuipc [5];
    funct3 = 3'b000; funct7 = 1'b0;
    op = 7'b0110111;
    expLui = '{
      {4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 3'b100, 4'b0000, 4'b1111, 3'b000},
      {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b100, 4'b0000, 4'b1111, 3'b000},
      {4'd12, 5'b00001, 2'b11, 2'b00, 2'b00, 3'b100, 4'b0000, 4'b1111, 3'b000},
      {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b100, 4'b0000, 4'b1111, 3'b000}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i == 0); #1;
      assertCount++;
      if (obs !== expLui[i]) begin failCount++; $display("[TB] FAIL lui_cycle%0d got %b want %b", i, obs, expLui[i]); end
    end
    expInstret++;
    op = 7'b0010111;
    expAuipc = '{
      {4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 3'b100, 4'b0000, 4'b1111, 3'b000},
      {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b100, 4'b0000, 4'b1111, 3'b000},
      {4'd13, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b100, 4'b0000, 4'b1111, 3'b000},
      {4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b100, 4'b0000, 4'b1111, 3'b000},
      {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b100, 4'b0000, 4'b1111, 3'b000}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = (i == 0); #1;
      assertCount++;
      if (obs !== expAuipc[i]) begin failCount++; $display("[TB] FAIL auipc_cycle%0d got %b want %b", i, obs, expAuipc[i]); end
    end
    expInstret++;
    assertCount++;
    if (instret !== expInstret) begin failCount++; $display("[TB] FAIL upper_instret got %0d want %0d", instret, expInstret); end
  endtask

  // ALU operation selection for R-type and I-type, including funct7 handling
  task automatic test_alu_decode();
    logic [6:0]  tOp  [12];
    logic [2:0]  tF3  [12];
    bit          tF7  [12];
    logic [3:0]  tAlu [12];
    logic [28:0] expVal;
    bit          isI;
    tOp  = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0010011,
             7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011};
    tF3  = '{3'b000, 3'b000, 3'b101, 3'b101, 3'b101, 3'b001,
             3'b010, 3'b011, 3'b100, 3'b110, 3'b111, 3'b010};
    tF7  = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    tAlu = '{4'b0001, 4'b0000, 4'b1011, 4'b1001, 4'b1011, 4'b1101,
             4'b0101, 4'b0100, 4'b0111, 4'b0011, 4'b0010, 4'b0101};
    for (int k = 0; k < 12; k++) begin
      op = tOp[k]; funct3 = tF3[k]; funct7 = tF7[k];
      isI = (tOp[k] == 7'b0010011);
      @(negedge clk); mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk); #1;
      expVal = {isI ? 4'd7 : 4'd6, 5'b00000, 2'b00, 2'b10, isI ? 2'b01 : 2'b00, 3'b000,
                tAlu[k], 4'b1111, 3'b000};
      assertCount++;
      if (obs !== expVal) begin failCount++; $display("[TB] FAIL alu_entry%0d got %b want %b", k, obs, expVal); end
      @(negedge clk);
      @(negedge clk); #1;
      expInstret++;
    end
    assertCount++;
    if (instret !== expInstret) begin failCount++; $display("[TB] FAIL alu_instret got %0d want %0d", instret, expInstret); end
  endtask

  // Reset asserted in the middle of a stalled store aborts it immediately
  task automatic test_reset_mid_write();
    logic [28:0] expSeq [4];
    logic [28:0] expVal;
    op = 7'b0100011; funct3 = 3'b010; funct7 = 1'b0;
    expSeq = '{
      {4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, 3'b001, 4'b0000, 4'b1111, 3'b000},
      {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b001, 4'b0000, 4'b1111, 3'b000},
      {4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 4'b1111, 3'b000},
      {4'd5, 5'b00110, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 4'b1010, 3'b000}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i == 0); #1;
      assertCount++;
      if (obs !== expSeq[i]) begin failCount++; $display("[TB] FAIL sw_cycle%0d got %b want %b", i, obs, expSeq[i]); end
    end
    #2; rst_n = 1'b0; mem_ready = 1'b1; #1;
    expInstret = 32'd0;
    expVal = {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b001, 4'b0000, 4'b1111, 3'b000};
    assertCount++;
    if (obs !== expVal) begin failCount++; $display("[TB] FAIL midwrite_abort got %b want %b", obs, expVal); end
    assertCount++;
    if (instret !== expInstret) begin failCount++; $display("[TB] FAIL midwrite_instret got %0d want %0d", instret, expInstret); end
    @(negedge clk); #1;
    assertCount++;
    if (obs !== expVal) begin failCount++; $display("[TB] FAIL midwrite_held got %b want %b", obs, expVal); end
    mem_ready = 1'b0; rst_n = 1'b1;
  endtask

  // Five lui instructions: the 2-bit counter wraps from 3 to 0
  task automatic test_instret_wrap();
    logic [29:0] nExp;
    op = 7'b0110111; funct3 = 3'b000; funct7 = 1'b0;
    nExp = {1'b0, 4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b100, 4'b0000, 4'b1111, 3'b000};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      expInstret++;
      assertCount++;
      if (instret !== expInstret) begin failCount++; $display("[TB] FAIL wrap%0d_instret got %0d want %0d", k, instret, expInstret); end
      assertCount++;
      if (nInstret !== expInstret[1:0]) begin failCount++; $display("[TB] FAIL wrap%0d_narrow got %0d want %0d", k, nInstret, expInstret[1:0]); end
    end
    assertCount++;
    if (nObs !== nExp) begin failCount++; $display("[TB] FAIL wrap_narrow_obs got %b want %b", nObs, nExp); end
  endtask

  // Illegal opcode and illegal branch funct3
  task automatic test_illegal();
    logic [28:0] expVal;
    op = 7'b0000000; funct3 = 3'b000; funct7 = 1'b0; BrEn = 1'b1;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0; #1;
    expVal = {4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 4'b0000, 4'b1111, 3'b000};
    assertCount++;
    if (obs !== expVal) begin failCount++; $display("[TB] FAIL illop_decode got %b want %b", obs, expVal); end
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      expVal = {4'd15, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 4'b1111, 3'b000};
      assertCount++;
      if ({obs, illegal} !== {expVal, 1'b1}) begin failCount++; $display("[TB] FAIL illop_trap%0d got %b want %b", i, {obs, illegal}, {expVal, 1'b1}); end
    end
    @(negedge clk); rst_n = 1'b0; mem_ready = 1'b0; #1; rst_n = 1'b1;
    expInstret = 32'd0;
`else
    @(negedge clk); #1;
    expVal = {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 4'b1111, 3'b000};
    assertCount++;
    if ({obs, illegal} !== {expVal, 1'b0}) begin failCount++; $display("[TB] FAIL illop_nop got %b want %b", {obs, illegal}, {expVal, 1'b0}); end
`endif
    assertCount++;
    if (instret !== expInstret) begin failCount++; $display("[TB] FAIL illop_instret got %0d want %0d", instret, expInstret); end
    op = 7'b1100011; funct3 = 3'b010;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    expVal = {4'd11, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b010, 4'b0001, 4'b1111, 3'b010};
    assertCount++;
    if (obs !== expVal) begin failCount++; $display("[TB] FAIL illbr_branch got %b want %b", obs, expVal); end
    @(negedge clk); #1;
`ifdef ILLEGAL_TRAP_EN
    expVal = {4'd15, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b010, 4'b0000, 4'b1111, 3'b000};
    assertCount++;
    if ({obs, illegal} !== {expVal, 1'b1}) begin failCount++; $display("[TB] FAIL illbr_trap got %b want %b", {obs, illegal}, {expVal, 1'b1}); end
`else
    expVal = {4'd0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b010, 4'b0000, 4'b1111, 3'b000};
    assertCount++;
    if ({obs, illegal} !== {expVal, 1'b0}) begin failCount++; $display("[TB] FAIL illbr_nop got %b want %b", {obs, illegal}, {expVal, 1'b0}); end
`endif
    assertCount++;
    if (instret !== expInstret) begin failCount++; $display("[TB] FAIL illbr_instret got %0d want %0d", instret, expInstret); end
    BrEn = 1'b0;
  endtask

  // Runaway guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout after %0d assertions", assertCount);
    $fatal(1, "[TB] simulation did not terminate");
  end

  // Test sequence
  initial begin
    test_reset();
    test_add();
    test_load();
    test_store();
    test_branch();
    test_jal();
    test_jalr();
    test_upper();
    test_alu_decode();
    test_reset_mid_write();
    test_instret_wrap();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
